// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8-entry register file (R0 hardwired zero), two combinational read ports, one write port, C/Z/N flags
module reg_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flag_en,
   input  logic              cb_in,
   output logic              flag_c,
   output logic              flag_z,
   output logic              flag_n
);

   localparam int NREG = 2 ** ADDR_W;

   // R0 has no storage; only R1..R(NREG-1) exist as flops
   logic [DATA_W-1:0] regs [NREG-1:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Flags track wr_data even when the write itself is discarded or disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (flag_en) begin
         flag_c <= cb_in;
         flag_z <= (wr_data == '0);
         flag_n <= wr_data[DATA_W-1];
      end
   end

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (rd_addr_a != '0) rd_data_a = regs[rd_addr_a];
      if (rd_addr_b != '0) rd_data_b = regs[rd_addr_b];
   end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file: directed vectors, monitor pops expectations on check strobes
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] rd_data_a, rd_data_b, wr_data;
   logic        wr_en, flag_en, cb_in;
   logic        flag_c, flag_z, flag_n;

   always #5 clk = ~clk;

   reg_file #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .flag_en   (flag_en),
      .cb_in     (cb_in),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .flag_n    (flag_n)
   );

   // mask bits: [2] port A, [1] port B, [0] flags; ef = {c, z, n}
   typedef struct {
      string       nm;
      logic [2:0]  mask;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [2:0]  ef;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic chk_req = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   always @(negedge clk) begin
      if (chk_req) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: strobe with no expectation queued");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.mask[2]) begin
               checks++;
               if (rd_data_a !== mon_e.ea) begin
                  errors++;
                  $display("FAIL %s port_a: got %h expected %h", mon_e.nm, rd_data_a, mon_e.ea);
               end
            end
            if (mon_e.mask[1]) begin
               checks++;
               if (rd_data_b !== mon_e.eb) begin
                  errors++;
                  $display("FAIL %s port_b: got %h expected %h", mon_e.nm, rd_data_b, mon_e.eb);
               end
            end
            if (mon_e.mask[0]) begin
               checks++;
               if ({flag_c, flag_z, flag_n} !== mon_e.ef) begin
                  errors++;
                  $display("FAIL %s flags(czn): got %b expected %b", mon_e.nm,
                           {flag_c, flag_z, flag_n}, mon_e.ef);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [2:0] mask, input logic [2:0] aa,
                      input logic [2:0] ab, input logic [15:0] ea, input logic [15:0] eb,
                      input logic [2:0] ef);
      exp_t e;
      rd_addr_a = aa;
      rd_addr_b = ab;
      e.nm = nm; e.mask = mask; e.ea = ea; e.eb = eb; e.ef = ef;
      sb.push_back(e);
      chk_req = 1'b1;
      @(negedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic fe, input logic cb);
      wr_en = we; wr_addr = wa; wr_data = wd; flag_en = fe; cb_in = cb;
   endtask

   // subtract model: a + ~b + 1, carry out kept raw
   function automatic logic [16:0] sub_model(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, a} + {1'b0, ~b} + 17'd1;
   endfunction

   logic [15:0] hold_exp [8];
   logic [16:0] res;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      tick();
      tick();
      chk("reset_state", 3'b111, 3'd7, 3'd3, 16'h0000, 16'h0000, 3'b000);
      tick();
      rst_n = 1'b1;

      // preload R3, then asynchronous reset mid-cycle
      drive(1'b1, 3'd3, 16'h1234, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("preload_r3", 3'b111, 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b100);
      tick();
      #2 rst_n = 1'b0;
      chk("async_reset", 3'b111, 3'd3, 3'd0, 16'h0000, 16'h0000, 3'b000);

      // write and flag update attempted while reset is held
      drive(1'b1, 3'd3, 16'h5555, 1'b1, 1'b1);
      tick();
      chk("write_blocked_in_reset", 3'b111, 3'd3, 3'd3, 16'h0000, 16'h0000, 3'b000);
      tick();
      rst_n = 1'b1;
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("first_write_after_reset", 3'b111, 3'd3, 3'd3, 16'h5555, 16'h5555, 3'b100);

      // no bypass: same-cycle read returns old contents
      tick();
      drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0);
      chk("no_bypass", 3'b110, 3'd5, 3'd5, 16'h0000, 16'h0000, 3'b000);
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("write_visible", 3'b110, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 3'b000);

      // R0 write discarded but flags still follow wr_data
      tick();
      drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b0);
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("r0_zero_flags", 3'b111, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b001);
      chk("r0_write_no_side_effect", 3'b110, 3'd5, 3'd3, 16'hBEEF, 16'h5555, 3'b000);

      // flags: zero result with carry, then hold with flag_en low
      tick();
      drive(1'b0, 3'd6, 16'h0000, 1'b1, 1'b1);
      tick();
      drive(1'b0, 3'd6, 16'h8000, 1'b0, 1'b0);
      chk("flags_zero_carry", 3'b001, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b110);
      tick();
      chk("flags_hold", 3'b001, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b110);

      // hold: wr_en low with varying address/data
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 3'(i), 16'(i * 16'h1111 + 16'h0101), 1'b0, 1'(i));
         tick();
      end
      hold_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
      for (int i = 0; i < 8; i += 2) begin
         chk($sformatf("hold_r%0d_r%0d", i, i + 1), 3'b111, 3'(i), 3'(i + 1),
             hold_exp[i], hold_exp[i + 1], 3'b110);
      end

      // adder loop: R1=5, R2=7, R3 = R1-R2, R4 = R2-R1, write and flags same edge
      tick();
      drive(1'b1, 3'd1, 16'h0005, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd2, 16'h0007, 1'b0, 1'b0);
      tick();
      rd_addr_a = 3'd1;
      rd_addr_b = 3'd2;
      res = sub_model(16'h0005, 16'h0007);
      drive(1'b1, 3'd3, res[15:0], 1'b1, res[16]);
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("sub_5_minus_7", 3'b111, 3'd3, 3'd1, 16'hFFFE, 16'h0005, 3'b001);
      tick();
      res = sub_model(16'h0007, 16'h0005);
      drive(1'b1, 3'd4, res[15:0], 1'b1, res[16]);
      tick();
      drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
      chk("sub_7_minus_5", 3'b111, 3'd4, 3'd2, 16'h0002, 16'h0007, 3'b100);

      // unknown address on port A must not disturb port B or state
      tick();
      chk("x_addr_isolated", 3'b011, 3'bxxx, 3'd5, 16'h0000, 16'hBEEF, 3'b100);
      chk("state_after_x", 3'b110, 3'd3, 3'd5, 16'hFFFE, 16'hBEEF, 3'b000);

      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
